// File: rtl/sprite_motion.sv
// Frame-rate sprite controller: position, lives and IDLE/ACTIVE/RESPAWN/OVER flow; MODE 0 player, MODE 1 patrol.
// Build option: define SPRITE_MOTION_VERT_EN to add vertical keyboard motion (keys 1A/16) in MODE 0.
module sprite_motion #(
  parameter int SIZE_X         = 25,
  parameter int SIZE_Y         = 25,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 639,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 479,
  parameter int X_STEP         = 3,
  parameter int Y_STEP         = 1,
  parameter int X_START        = 320,
  parameter int Y_START        = 440,
  parameter int MODE           = 0,
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       hit,
  output logic [9:0] PosX,
  output logic [9:0] PosY,
  output logic [9:0] SizeX,
  output logic [9:0] SizeY,
  output logic       active,
  output logic [2:0] lives_left,
  output logic       game_over
);

  localparam logic [10:0] X_LO         = 11'(X_MIN);
  localparam logic [10:0] X_HI         = 11'(X_MAX - SIZE_X + 1);
  localparam logic [10:0] Y_LO         = 11'(Y_MIN);
  localparam logic [10:0] Y_HI         = 11'(Y_MAX - SIZE_Y + 1);
  localparam logic [10:0] X_INC        = 11'(X_STEP);
  localparam logic [10:0] Y_INC        = 11'(Y_STEP);
  localparam logic [9:0]  X_HOME       = 10'(X_START);
  localparam logic [9:0]  Y_HOME       = 10'(Y_START);
  localparam logic [2:0]  LIVES_INIT   = 3'(LIVES);
  localparam logic [9:0]  RESPAWN_LOAD = 10'(RESPAWN_FRAMES);
  localparam logic [7:0]  KEY_START    = 8'h2C;
  localparam logic [7:0]  KEY_LEFT     = 8'h04;
  localparam logic [7:0]  KEY_RIGHT    = 8'h07;
`ifdef SPRITE_MOTION_VERT_EN
  localparam logic [7:0]  KEY_UP       = 8'h1A;
  localparam logic [7:0]  KEY_DOWN     = 8'h16;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RESPAWN, S_OVER} state_e;
  typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_e;

  // Saturating step: subtraction is guarded by a compare so it can never wrap below lo.
  function automatic logic [10:0] sat_step(input logic [10:0] v, input logic [10:0] s,
                                           input logic up, input logic [10:0] lo,
                                           input logic [10:0] hi);
    logic [10:0] r;
    if (up) r = (v + s >= hi) ? hi : v + s;
    else    r = (v <= lo + s) ? lo : v - s;
    return r;
  endfunction

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d, mv_dir;
  logic [9:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d, mv_x, mv_y;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  lives_q, lives_d, lives_dec;
  logic        active_q, active_d, game_over_q, game_over_d;
  logic [10:0] x_ext, y_ext, nx;

  assign x_ext     = {1'b0, pos_x_q};
  assign y_ext     = {1'b0, pos_y_q};
  assign lives_dec = lives_q - 3'd1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    mv_x   = pos_x_q;
    mv_y   = pos_y_q;
    mv_dir = dir_q;
    nx     = x_ext;
    if (MODE == 0) begin
      if (keycode == KEY_LEFT)       mv_x = 10'(sat_step(x_ext, X_INC, 1'b0, X_LO, X_HI));
      else if (keycode == KEY_RIGHT) mv_x = 10'(sat_step(x_ext, X_INC, 1'b1, X_LO, X_HI));
`ifdef SPRITE_MOTION_VERT_EN
      if (keycode == KEY_UP)         mv_y = 10'(sat_step(y_ext, Y_INC, 1'b0, Y_LO, Y_HI));
      else if (keycode == KEY_DOWN)  mv_y = 10'(sat_step(y_ext, Y_INC, 1'b1, Y_LO, Y_HI));
`endif
    end else begin
      nx   = sat_step(x_ext, X_INC, dir_q == DIR_RIGHT, X_LO, X_HI);
      mv_x = 10'(nx);
      // Touching an edge turns the patrol around and drops it one row in the same frame.
      if ((dir_q == DIR_RIGHT && nx == X_HI) || (dir_q == DIR_LEFT && nx == X_LO)) begin
        mv_dir = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
        mv_y   = 10'(sat_step(y_ext, Y_INC, 1'b1, Y_LO, Y_HI));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    unique case (state_q)
      S_IDLE: begin
        if (keycode == KEY_START) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (hit) begin
          lives_d = lives_dec;
          if (lives_dec == 3'd0) begin
            state_d = S_OVER;
          end else begin
            state_d = S_RESPAWN;
            cnt_d   = RESPAWN_LOAD;
            pos_x_d = X_HOME;
            pos_y_d = Y_HOME;
            dir_d   = DIR_RIGHT;
          end
        end else begin
          pos_x_d = mv_x;
          pos_y_d = mv_y;
          dir_d   = mv_dir;
        end
      end
      S_RESPAWN: begin
        cnt_d = cnt_q - 10'd1;
        if (cnt_q == 10'd1) state_d = S_ACTIVE;
      end
      S_OVER: begin
        if (keycode == KEY_START) begin
          state_d = S_ACTIVE;
          lives_d = LIVES_INIT;
          pos_x_d = X_HOME;
          pos_y_d = Y_HOME;
          dir_d   = DIR_RIGHT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    active_d    = (state_d == S_ACTIVE);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge frame_clk) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge values.
    if (Reset) begin
      state_q     <= S_IDLE;
      pos_x_q     <= X_HOME;
      pos_y_q     <= Y_HOME;
      dir_q       <= DIR_RIGHT;
      cnt_q       <= 10'd0;
      lives_q     <= LIVES_INIT;
      active_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      lives_q     <= lives_d;
      active_q    <= active_d;
      game_over_q <= game_over_d;
    end
  end

  assign PosX       = pos_x_q;
  assign PosY       = pos_y_q;
  assign SizeX      = 10'(SIZE_X);
  assign SizeY      = 10'(SIZE_Y);
  assign active     = active_q;
  assign lives_left = lives_q;
  assign game_over  = game_over_q;

endmodule

// File: doc/sprite_motion.md
SPRITE_MOTION -- requirements
Module: sprite_motion

Interface
REQ-001 Parameter SIZE_X, 25, sprite width in pixels.
REQ-002 Parameter SIZE_Y, 25, sprite height in pixels.
REQ-003 Parameters X_MIN/X_MAX/Y_MIN/Y_MAX, 0/639/0/479, inclusive playfield bounds.
REQ-004 Parameters X_STEP/Y_STEP, 3/1, pixels moved per frame per axis.
REQ-005 Parameters X_START/Y_START, 320/440, spawn position (top-left corner).
REQ-006 Parameter MODE, 0, 0 = keyboard-driven player, 1 = autonomous patrol (enemy).
REQ-007 Parameter LIVES, 3, lives at game start (1..7).
REQ-008 Parameter RESPAWN_FRAMES, 60, frames spent in respawn (1..1023).
REQ-009 frame_clk  input  1  single clock, one edge per video frame.
REQ-010 Reset  input  1  synchronous, active-high reset.
REQ-011 keycode  input  8  current USB keycode.
REQ-012 hit  input  1  collision pulse from collision logic.
REQ-013 PosX, PosY  output  10 each  sprite top-left position.
REQ-014 SizeX, SizeY  output  10 each  constant SIZE_X, SIZE_Y.
REQ-015 active  output  1  high only in ACTIVE (sprite drawable/collidable).
REQ-016 lives_left  output  3  remaining lives.
REQ-017 game_over  output  1  high only in OVER.

Function
REQ-018 FSM states: IDLE, ACTIVE, RESPAWN, OVER; all transitions evaluated on frame_clk rising edge.
REQ-019 IDLE: position held at start; keycode 8'h2C -> ACTIVE next frame; hit ignored.
REQ-020 ACTIVE: hit=1 -> lives_left decremented; if result 0 -> OVER, else -> RESPAWN with counter loaded to RESPAWN_FRAMES and position reloaded to start.
REQ-021 ACTIVE: hit has priority over movement; no position change in a hit frame.
REQ-022 ACTIVE: keycode 8'h2C ignored (no restart mid-game).
REQ-023 RESPAWN: counter decrements each frame; position held; hit ignored; counter reaching 0 -> ACTIVE in that same edge.
REQ-024 OVER: position held; 8'h2C -> ACTIVE with lives_left = LIVES, position = start.
REQ-025 Movement computes next position combinationally and registers it in the same edge; no one-frame-stale motion term.
REQ-026 Arithmetic in 11 bits; X range [X_MIN, X_MAX-SIZE_X+1], Y range [Y_MIN, Y_MAX-SIZE_Y+1]; out-of-range results saturate to range edge, never wrap.
REQ-027 MODE 0: keycode 8'h04 moves X by -X_STEP, 8'h07 by +X_STEP, any other code -> no motion.
REQ-028 MODE 1: direction register (reset: right); X moves X_STEP per frame; on reaching/clamping at an X edge, direction reverses and Y advances +Y_STEP in that same frame (saturating); keycode ignored except 8'h2C in IDLE/OVER.
REQ-029 MODE 1 Y saturated at bottom edge: X patrol continues, Y holds.

Reset
REQ-030 Reset=1 at an edge: state IDLE, PosX=X_START, PosY=Y_START, lives_left=LIVES, respawn counter 0, direction right, active=0, game_over=0.
REQ-031 Reset overrides all other inputs in any state, including mid-RESPAWN.

Configuration
REQ-032 Macro SPRITE_MOTION_VERT_EN defined: MODE 0 also accepts 8'h1A (Y -= Y_STEP) and 8'h16 (Y += Y_STEP), saturating per REQ-026.
REQ-033 Macro undefined: MODE 0 PosY constant at Y_START; 8'h1A/8'h16 treated as no-motion; MODE 1 unaffected.

Verification
REQ-034 Reset, keycode 2C, then 04 for 200 frames, MODE 0 -> PosX 320 -> 317 after first ACTIVE frame, saturates at 0, never wraps to 1023.
REQ-035 MODE 0, 07 held -> PosX stops at 615 (639-25+1), PosY 440 throughout without SPRITE_MOTION_VERT_EN.
REQ-036 ACTIVE, hit one frame with 07 held -> lives_left 3->2, RESPAWN, PosX=320, active=0 for 60 frames, then ACTIVE; hit during RESPAWN no effect.
REQ-037 Three hits across respawns -> lives_left 0, game_over=1; keycode 2C -> ACTIVE, lives_left=3, PosX/PosY=320/440.
REQ-038 MODE 1 from X_START=600 -> PosX 603..615 clamp, same frame direction left and PosY 441; next frame PosX 612.
REQ-039 Reset asserted mid-RESPAWN (counter 30) -> next edge IDLE, lives_left=3, counter 0, PosX/PosY=320/440.
